// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC register master: FSM states, register
// addresses, control-word field offsets and the duty ramp step helper.
package bldc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_CAP,
        ST_WAIT,
        ST_ABORT_WR
    } state_t;

    localparam logic ADDR_CTRL = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

    localparam int EN_BIT   = 15;
    localparam int DUTY_LSB = 16;
    localparam int VEL_LSB  = 24;

    // Move cur toward tgt by at most stp (0 behaves as 1). Nine-bit
    // intermediates catch overflow/underflow so the result never wraps and
    // the last step lands exactly on the target.
    function automatic logic [7:0] duty_step(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] stp);
        logic [8:0] s9;
        logic [8:0] sum9;
        logic [8:0] dif9;
        logic [7:0] res;
        s9   = (stp == 8'd0) ? 9'd1 : {1'b0, stp};
        sum9 = {1'b0, cur} + s9;
        dif9 = {1'b0, cur} - s9;
        if (tgt > cur) begin
            res = (sum9 >= {1'b0, tgt}) ? tgt : sum9[7:0];
        end else if (tgt < cur) begin
            res = (dif9[8] || (dif9[7:0] <= tgt)) ? tgt : dif9[7:0];
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/bldc_tick_div.sv
// Interval counter for the ramp WAIT phase: while clr_i is low it counts and
// raises tick_o on the cycle that completes DIV-1 counted cycles.
// DIV below 2 behaves like DIV = 2 (a single WAIT cycle).
module bldc_tick_div #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int TERM = (DIV > 2) ? DIV - 2 : 0;
    localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = !clr_i && (cnt_q == CW'(TERM));

    // Next count: restart on clear or on the terminal count, else advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bldc_reg_master.sv
// BLDC register master: ramps the motor duty toward a target by writing the
// control register once per update interval, reading back status after each
// write. A stop pulse writes a disable word and returns to idle.
module bldc_reg_master
    import bldc_pkg::*;
#(
    parameter int UPDATE_DIV = 50000,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        target_duty,
    input  logic [7:0]        target_vel,
    input  logic [7:0]        step,
    output logic              write,
    output logic              read,
    output logic              addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic [7:0]        cur_duty,
    output logic [DATA_W-1:0] status,
    output logic              status_valid,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [7:0]        tgt_q, step_q, vel_q;
    logic [7:0]        cur_duty_q, nxt_duty;
    logic              write_q, read_q, addr_q;
    logic [DATA_W-1:0] data_in_q, status_q;
    logic              status_valid_q, done_q, busy_q;
    logic              latch_targets, done_d, tick;
    logic [7:0]        wr_vel;

    function automatic logic [DATA_W-1:0] ctrl_word(input logic [7:0] vel,
                                                    input logic [7:0] duty,
                                                    input logic       en);
        logic [DATA_W-1:0] w;
        w                   = '0;
        w[VEL_LSB +: 8]     = vel;
        w[DUTY_LSB +: 8]    = duty;
        w[EN_BIT]           = en;
        return w;
    endfunction

    bldc_tick_div #(.DIV(UPDATE_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != ST_WAIT),
        .tick_o (tick)
    );

    // Next-state and next-duty decode; stop overrides every other transition.
    always_comb begin
        state_d       = state_q;
        nxt_duty      = cur_duty_q;
        latch_targets = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_WR;
                    latch_targets = 1'b1;
                    nxt_duty      = duty_step(cur_duty_q, target_duty, step);
                end
            end
            ST_WR:       state_d = ST_RD;
            ST_RD:       state_d = ST_CAP;
            ST_CAP:      state_d = (cur_duty_q == tgt_q) ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (tick) begin
                    state_d  = ST_WR;
                    nxt_duty = duty_step(cur_duty_q, tgt_q, step_q);
                end
            end
            ST_ABORT_WR: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        if (stop) begin
            state_d       = ST_ABORT_WR;
            latch_targets = 1'b0;
        end
    end

    assign done_d = (state_q == ST_CAP) && (state_d == ST_IDLE);
    // The first write of a ramp carries the velocity being latched that edge.
    assign wr_vel = latch_targets ? target_vel : vel_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered bus strobes, data, duty and status, all keyed on the state
    // being entered so every output is glitch-free and aligned with its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_q          <= '0;
            step_q         <= '0;
            vel_q          <= '0;
            write_q        <= 1'b0;
            read_q         <= 1'b0;
            addr_q         <= ADDR_CTRL;
            data_in_q      <= '0;
            cur_duty_q     <= '0;
            status_q       <= '0;
            status_valid_q <= 1'b0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            if (latch_targets) begin
                tgt_q  <= target_duty;
                step_q <= step;
                vel_q  <= target_vel;
            end
            write_q <= (state_d == ST_WR) || (state_d == ST_ABORT_WR);
            read_q  <= (state_d == ST_RD);
            addr_q  <= (state_d == ST_RD) ? ADDR_STAT : ADDR_CTRL;
            if (state_d == ST_WR) begin
                cur_duty_q <= nxt_duty;
                data_in_q  <= ctrl_word(wr_vel, nxt_duty, 1'b1);
            end else if (state_d == ST_ABORT_WR) begin
                cur_duty_q <= 8'd0;
                data_in_q  <= ctrl_word(vel_q, 8'd0, 1'b0);
            end
            status_valid_q <= (state_q == ST_CAP);
            if (state_q == ST_CAP) begin
                status_q <= data_out;
            end
            done_q <= done_d;
            busy_q <= (state_d != ST_IDLE);
        end
    end

    assign write        = write_q;
    assign read         = read_q;
    assign addr         = addr_q;
    assign data_in      = data_in_q;
    assign cur_duty     = cur_duty_q;
    assign status       = status_q;
    assign status_valid = status_valid_q;
    assign done         = done_q;
    assign busy         = busy_q;

endmodule
